// File: rtl/tropang_pkg.sv
// Shared types and constants for the Tropical Angel NVRAM upload path.
package tropang_pkg;

  // Upload read sequencer states.
  typedef enum logic [1:0] {
    UP_IDLE    = 2'd0,
    UP_FETCH   = 2'd1,
    UP_DELIVER = 2'd2
  } up_state_t;

  // Byte returned for reads outside the saved region or after a failed fetch.
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  // Select byte lane of a 16-bit memory word; lane 0 is the low byte.
  function automatic logic [7:0] pick_lane(input logic [15:0] word, input logic lane);
    return lane ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/toggle_req_port.sv
// Toggle request/acknowledge memory port: one req toggle per fetch, completion
// when the responder's ack parity matches, with a bounded wait for that ack.
module toggle_req_port #(
  parameter int            AW      = 16,
  parameter int            TW      = 10,
  parameter logic [TW-1:0] TIMEOUT = '1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] addr,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic [AW-1:0] mem_a,
  output logic          done,
  output logic          timed_out
);

  logic          busy;
  logic [TW-1:0] tmo_cnt;
  logic          ack_match;

  // The ack is same-domain, so it is compared combinationally.
  assign ack_match = (mem_ack == mem_req);
  assign done      = busy & ack_match;
  assign timed_out = busy & ~ack_match & (tmo_cnt == TIMEOUT);

  // Request toggle, address register and ack-wait counter; abort keeps the
  // req parity so an ack landing afterwards simply re-aligns the pair.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mem_req <= 1'b0;
      mem_a   <= '0;
      busy    <= 1'b0;
      tmo_cnt <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      mem_req <= ~mem_req;
      mem_a   <= addr;
      busy    <= 1'b1;
      tmo_cnt <= '0;
    end else if (busy) begin
      if (ack_match || (tmo_cnt == TIMEOUT)) begin
        busy <= 1'b0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tropang_nvram_upload.sv
// HPS upload reader for the hiscore/NVRAM region: serves byte reads from a
// one-word cache, fetching 16-bit words over a toggle handshake on a miss.
module tropang_nvram_upload
  import tropang_pkg::*;
#(
  parameter logic [7:0]  UPLOAD_INDEX = 8'd4,
  parameter logic [16:0] SIZE_BYTES   = 17'h00800,
  parameter logic [15:0] BASE_WORD    = 16'h0000,
  parameter logic [9:0]  TIMEOUT      = 10'd1023
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        cpu_pause,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [15:0] mem_a,
  input  logic [15:0] mem_q,
  output logic        err
);

  up_state_t   state;
  logic        active;
  logic        out_of_range;
  logic [15:0] word_idx;
  logic [15:0] fetch_addr;
  logic        hit;
  logic        fetch_start;
  logic        fetch_abort;
  logic        fetch_done;
  logic        fetch_tmo;

  // Cache: data, tag and lane are plain data; only the valid bit is control.
  logic [15:0] cache_q;
  logic [15:0] cache_tag;
  logic        cache_vld;
  logic        lane;

  assign active       = ioctl_upload & (ioctl_index == UPLOAD_INDEX);
  assign out_of_range = (ioctl_addr >= {8'd0, SIZE_BYTES});
  assign word_idx     = ioctl_addr[16:1];
  assign fetch_addr   = BASE_WORD + word_idx;
  assign hit          = cache_vld & (cache_tag == word_idx);
  assign fetch_start  = (state == UP_IDLE) & active & ioctl_rd & ~out_of_range & ~hit;
  assign fetch_abort  = ~active;

  toggle_req_port #(
    .AW      (16),
    .TW      (10),
    .TIMEOUT (TIMEOUT)
  ) u_port (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .start     (fetch_start),
    .abort     (fetch_abort),
    .addr      (fetch_addr),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_a     (mem_a),
    .done      (fetch_done),
    .timed_out (fetch_tmo)
  );

  // Game core freeze follows the upload selection one cycle late.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cpu_pause <= 1'b0;
    end else begin
      cpu_pause <= active;
    end
  end

  // Read sequencer: answer hits and out-of-range reads directly, otherwise
  // stall the HPS until the word arrives or the fetch times out.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= UP_IDLE;
      ioctl_wait <= 1'b0;
      ioctl_din  <= 8'd0;
      err        <= 1'b0;
      cache_vld  <= 1'b0;
    end else if (!active) begin
      state      <= UP_IDLE;
      ioctl_wait <= 1'b0;
      cache_vld  <= 1'b0;
    end else begin
      case (state)
        UP_IDLE: begin
          if (ioctl_rd) begin
            if (out_of_range) begin
              ioctl_din <= FILL_BYTE;
            end else if (hit) begin
              ioctl_din <= pick_lane(cache_q, ioctl_addr[0]);
            end else begin
              ioctl_wait <= 1'b1;
              cache_vld  <= 1'b0;
              state      <= UP_FETCH;
            end
          end
        end
        UP_FETCH: begin
          if (fetch_done) begin
            cache_vld <= 1'b1;
            state     <= UP_DELIVER;
          end else if (fetch_tmo) begin
            ioctl_din  <= FILL_BYTE;
            err        <= 1'b1;
            ioctl_wait <= 1'b0;
            state      <= UP_IDLE;
          end
        end
        UP_DELIVER: begin
          ioctl_din  <= pick_lane(cache_q, lane);
          ioctl_wait <= 1'b0;
          state      <= UP_IDLE;
        end
        default: begin
          state <= UP_IDLE;
        end
      endcase
    end
  end

  // Cache data path: tag and lane latch at fetch launch, word at ack.
  always_ff @(posedge clk_sys) begin
    if (fetch_start) begin
      cache_tag <= word_idx;
      lane      <= ioctl_addr[0];
    end
    if ((state == UP_FETCH) && fetch_done) begin
      cache_q <= mem_q;
    end
  end

endmodule

// File: tb/tb_tropang_nvram_upload.sv
// Scoreboard bench for tropang_nvram_upload with a toggle-handshake responder.
module tb_tropang_nvram_upload;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        cpu_pause;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_a;
  logic [15:0] mem_q;
  logic        err;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  sb[$];

  // Responder control, written only by the stimulus process.
  int          ack_mode  = 0;   // 0 auto-ack, 1 never ack, 2 drive ack_force
  logic        ack_force = 1'b0;
  int          rsp_delay = 5;
  logic [15:0] rsp_data  = 16'h0000;

  always #5 clk_sys = ~clk_sys;

  tropang_nvram_upload dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ioctl_upload (ioctl_upload),
    .ioctl_index  (ioctl_index),
    .ioctl_rd     (ioctl_rd),
    .ioctl_addr   (ioctl_addr),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .cpu_pause    (cpu_pause),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .mem_a        (mem_a),
    .mem_q        (mem_q),
    .err          (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: copies mem_req onto mem_ack rsp_delay cycles after a toggle.
  initial begin
    int   cnt;
    logic pend;
    logic last;
    cnt = 0; pend = 1'b0; last = 1'b0;
    mem_ack = 1'b0; mem_q = 16'h0000;
    forever begin
      @(posedge clk_sys); #2;
      if (reset) begin
        mem_ack = 1'b0; pend = 1'b0; last = 1'b0;
      end else if (ack_mode == 2) begin
        mem_ack = ack_force; pend = 1'b0; last = mem_req;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            mem_ack = mem_req; mem_q = rsp_data; pend = 1'b0;
          end
        end else if ((mem_req != last) && (ack_mode == 0)) begin
          pend = 1'b1; cnt = rsp_delay;
        end
        last = mem_req;
      end
    end
  end

  // Monitor: a response is a strobe answered with wait low, or wait falling.
  initial begin
    logic       rd_p, wait_p, act_p, rst_p;
    logic [7:0] exp;
    rd_p = 1'b0; wait_p = 1'b0; act_p = 1'b0; rst_p = 1'b1;
    forever begin
      @(negedge clk_sys);
      if (!reset && !rst_p && act_p &&
          ((rd_p && !wait_p && !ioctl_wait) || (wait_p && !ioctl_wait))) begin
        if (sb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_rsp: got din %0h, expected no response", ioctl_din);
        end else begin
          exp = sb.pop_front();
          chk("rsp_din", {24'd0, ioctl_din}, {24'd0, exp});
        end
      end
      rd_p   = ioctl_rd;
      wait_p = ioctl_wait;
      act_p  = ioctl_upload && (ioctl_index == 8'd4);
      rst_p  = reset;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_read(input string tag, input logic [24:0] a, input bit exp_rsp,
                         input logic [7:0] exp_din, input bit exp_tog,
                         input logic [15:0] exp_mema, input int exp_wait);
    logic req0;
    int   wcnt;
    if (exp_rsp) sb.push_back(exp_din);
    @(posedge clk_sys); #1;
    req0 = mem_req; ioctl_rd = 1'b1; ioctl_addr = a;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    @(negedge clk_sys);
    chk({tag, "_req"}, {31'd0, mem_req}, {31'd0, req0 ^ exp_tog});
    if (exp_tog) chk({tag, "_mema"}, {16'd0, mem_a}, {16'd0, exp_mema});
    wcnt = 0;
    while (ioctl_wait && wcnt < 3000) begin
      wcnt++;
      @(negedge clk_sys);
    end
    chk({tag, "_wait"}, wcnt, exp_wait);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_din"},   {24'd0, ioctl_din}, 32'h0);
    chk({tag, "_wait"},  {31'd0, ioctl_wait}, 32'h0);
    chk({tag, "_pause"}, {31'd0, cpu_pause}, 32'h0);
    chk({tag, "_req"},   {31'd0, mem_req}, 32'h0);
    chk({tag, "_mema"},  {16'd0, mem_a}, 32'h0);
    chk({tag, "_err"},   {31'd0, err}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; ioctl_upload = 1'b0; ioctl_index = 8'd0;
    ioctl_rd = 1'b0; ioctl_addr = '0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk_reset_vals("rst");
    @(posedge clk_sys); #1; reset = 1'b0;

    // Start upload; pause lags selection by one cycle.
    @(posedge clk_sys); #1; ioctl_upload = 1'b1; ioctl_index = 8'd4;
    @(negedge clk_sys); chk("pause_lag0", {31'd0, cpu_pause}, 32'd0);
    @(negedge clk_sys); chk("pause_on",   {31'd0, cpu_pause}, 32'd1);

    // Miss, hit, out of range, top of region.
    rsp_data = 16'hBEEF; rsp_delay = 5;
    do_read("miss3", 25'h0003, 1, 8'hBE, 1, 16'h0001, 7);
    do_read("hit2",  25'h0002, 1, 8'hEF, 0, 16'h0000, 0);
    do_read("oor800", 25'h0800, 1, 8'hFF, 0, 16'h0000, 0);
    do_read("oorbit24", 25'h1000003, 1, 8'hFF, 0, 16'h0000, 0);
    rsp_data = 16'h1234;
    do_read("miss7ff", 25'h07FF, 1, 8'h12, 1, 16'h03FF, 7);

    // Other index: no response, no pause.
    @(posedge clk_sys); #1; ioctl_index = 8'd3;
    @(negedge clk_sys); chk("idx3_pause_lag", {31'd0, cpu_pause}, 32'd1);
    @(negedge clk_sys); chk("idx3_pause_off", {31'd0, cpu_pause}, 32'd0);
    do_read("idx3", 25'h07FF, 0, 8'h00, 0, 16'h0000, 0);
    chk("idx3_din", {24'd0, ioctl_din}, 32'h12);

    // Restart: cache was invalidated, so the old word is fetched again.
    @(posedge clk_sys); #1; ioctl_index = 8'd4;
    @(negedge clk_sys); chk("re_pause_lag", {31'd0, cpu_pause}, 32'd0);
    @(negedge clk_sys); chk("re_pause_on",  {31'd0, cpu_pause}, 32'd1);
    rsp_data = 16'hA55A;
    do_read("refetch", 25'h07FE, 1, 8'h5A, 1, 16'h03FF, 7);

    // Timeout with a silent responder.
    ack_mode = 1;
    do_read("tmo", 25'h0010, 1, 8'hFF, 1, 16'h0008, 1024);
    chk("tmo_err", {31'd0, err}, 32'd1);
    // Responder catches up on the abandoned request, then retry the word.
    @(posedge clk_sys); #1; ack_mode = 2; ack_force = mem_req;
    @(posedge clk_sys); @(posedge clk_sys); #1; ack_mode = 0;
    rsp_data = 16'h7788; rsp_delay = 2;
    do_read("retry", 25'h0010, 1, 8'h88, 1, 16'h0008, 4);
    chk("retry_err_sticky", {31'd0, err}, 32'd1);

    // Reset in the middle of a fetch.
    rsp_delay = 20;
    @(posedge clk_sys); #1; ioctl_rd = 1'b1; ioctl_addr = 25'h0020;
    @(posedge clk_sys); #1; ioctl_rd = 1'b0;
    @(negedge clk_sys); chk("rf_wait_hi", {31'd0, ioctl_wait}, 32'd1);
    repeat (3) @(posedge clk_sys);
    #1; reset = 1'b1;
    @(posedge clk_sys); #1; reset = 1'b0;
    @(negedge clk_sys);
    chk_reset_vals("rf");
    // Late ack after reset must not disturb anything.
    @(posedge clk_sys); #1; ack_mode = 2; ack_force = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1; ack_force = 1'b0;
    @(negedge clk_sys);
    chk("late_wait", {31'd0, ioctl_wait}, 32'd0);
    chk("late_din",  {24'd0, ioctl_din}, 32'd0);
    chk("late_req",  {31'd0, mem_req}, 32'd0);
    @(posedge clk_sys); @(posedge clk_sys); #1; ack_mode = 0;
    rsp_data = 16'hCAFE; rsp_delay = 3;
    do_read("after_rst", 25'h0022, 1, 8'hFE, 1, 16'h0011, 5);
    chk("after_rst_req1", {31'd0, mem_req}, 32'd1);

    // Strobe in the same cycle the upload ends is ignored.
    @(posedge clk_sys); #1;
    ioctl_upload = 1'b0; ioctl_rd = 1'b1; ioctl_addr = 25'h0023;
    @(posedge clk_sys); #1; ioctl_rd = 1'b0;
    @(negedge clk_sys);
    chk("fall_din",  {24'd0, ioctl_din}, 32'hFE);
    chk("fall_wait", {31'd0, ioctl_wait}, 32'd0);
    chk("fall_req",  {31'd0, mem_req}, 32'd1);
    chk("fall_pause", {31'd0, cpu_pause}, 32'd0);

    repeat (3) @(posedge clk_sys);
    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tropang_nvram_upload.md
# tropang_nvram_upload

Serves HPS upload reads (FPGA→HPS, the reverse of ROM download) so the hiscore/NVRAM region of Tropical Angel work RAM can be saved to SD. Sits between `hps_io` upload signals and a 16-bit memory port that uses the toggle request/acknowledge handshake. Fetches 16-bit words on demand, keeps a one-word cache, and stalls the HPS with `ioctl_wait` while a fetch is in flight. The game CPU is paused for the whole upload.

## Interface
- `UPLOAD_INDEX`, default 8'd4: `ioctl_index` value that selects this block.
- `SIZE_BYTES`, default 17'h00800: number of valid bytes; reads at or above this return 8'hFF.
- `BASE_WORD`, default 16'h0000: word address of byte 0 in memory space.
- `TIMEOUT`, default 10'd1023: `clk_sys` cycles to wait for an ack before giving up.
- `clk_sys`  in  1  system clock; everything is synchronous to it.
- `reset`  in  1  synchronous, active-high.
- `ioctl_upload`  in  1  HPS upload active.
- `ioctl_index`  in  8  selected file index.
- `ioctl_rd`  in  1  one-cycle read strobe.
- `ioctl_addr`  in  25  byte address.
- `ioctl_din`  out  8  byte returned to the HPS.
- `ioctl_wait`  out  1  HPS must hold off the next strobe.
- `cpu_pause`  out  1  freeze request to the game core.
- `mem_req`  out  1  toggles once per fetch.
- `mem_ack`  in  1  the responder copies `mem_req` when data is valid.
- `mem_a`  out  16  word address.
- `mem_q`  in  16  read data; byte 0 is `[7:0]`.
- `err`  out  1  sticky timeout flag.

## Operation
- `active` = `ioctl_upload & (ioctl_index == UPLOAD_INDEX)`.
- `cpu_pause` is registered and equals `active` delayed by one cycle.
- State machine states: IDLE, FETCH, DELIVER.
- **IDLE**, when `ioctl_rd & active` is seen:
  - Out of range (`ioctl_addr >= SIZE_BYTES`): set `ioctl_din`=FF. No fetch.
  - Cache hit (word `ioctl_addr[16:1]` equals the cached tag and the cache is valid): `ioctl_din` is the selected byte of the cached word. No fetch.
  - Otherwise: set `mem_a` = `BASE_WORD + ioctl_addr[16:1]`, toggle `mem_req`, set `ioctl_wait`=1, latch `ioctl_addr[0]`, clear the timeout counter, go to FETCH.
- **FETCH**:
  - On `mem_ack == mem_req`: capture `mem_q` into the cache, set tag and valid, go to DELIVER.
  - Timeout (counter reaches `TIMEOUT`): `ioctl_din`=FF, set `err`, leave the cache invalid, go to IDLE with `ioctl_wait`=0.
- **DELIVER**: drive `ioctl_din` from the latched lane, set `ioctl_wait`=0, go to IDLE.
- Ignored inputs:
  - `ioctl_rd` while not in IDLE.
  - `ioctl_rd` while `active` is 0.
- When `active` falls:
  - The cache is invalidated.
  - The FSM is forced to IDLE and `ioctl_wait` is cleared.
  - `mem_req` parity is kept, so a late ack is harmless.
- Address arithmetic: `mem_a` is 16 bits and wraps modulo 2^16. `SIZE_BYTES` is compared against the full `ioctl_addr[24:0]`.

## Timing
- Reset values:
  - `ioctl_din`=0, `ioctl_wait`=0, `cpu_pause`=0, `mem_req`=0, `mem_a`=0, `err`=0.
  - Cache invalid, state IDLE.
  - The responder must reset its ack to 0 at the same time.
- Hit or out-of-range read: strobe in cycle N, `ioctl_din` valid in N+1. `ioctl_wait` stays 0.
- Miss:
  - Strobe in cycle N; `ioctl_wait`=1 and `mem_req` toggled in N+1.
  - Ack match in cycle M; `ioctl_din` valid and `ioctl_wait`=0 in M+2.
  - `mem_ack` is compared unregistered (same clock domain).
- Timeout: `ioctl_wait` drops in cycle N+1+`TIMEOUT`+1.
- `err` clears only on `reset`.
- Reset during FETCH: outputs return to their reset values in the next cycle. An ack arriving after that is ignored.
- Strobe in the same cycle that `active` falls: ignored.

## Structure
- `tropang_pkg` holds the state enum (`up_state_t`) and the FF fill constant.
- One natural sub-module, `toggle_req_port`, containing:
  - the req/ack toggle;
  - the `mem_a` register;
  - the timeout counter.
- It is reusable by the sound-ROM and sprite-ROM ports.

## Test plan
- Miss: upload index 4, `ioctl_rd` at addr 0x0003. Responder acks after 5 cycles with `mem_q`=16'hBEEF. Required: `mem_a`=0x0001, `ioctl_din`=8'hBE, `ioctl_wait` high for 7 cycles.
- Cache hit: after the previous case, read addr 0x0002. Required: `ioctl_din`=8'hEF next cycle, no `mem_req` toggle.
- Out of range: read addr 0x0800. Required: `ioctl_din`=FF, `mem_req` unchanged. Also read at index 3. Required: no response and `cpu_pause`=0.
- Timeout: responder never acks. Required: `ioctl_wait` falls after 1025 cycles, `ioctl_din`=FF, `err`=1.
- Reset during FETCH: all outputs reach reset values next cycle. A late ack causes no state change. The next miss toggles `mem_req` 0→1.
- Upload ends and restarts: cache invalidated, so rereading addr 0x0002 issues a new fetch. `cpu_pause` tracks `active` with a one-cycle lag.
